// File: rtl/clk_hub_div_if.sv
// clk_hub_div_if: bundle of the eight divided clock outputs of the hub
interface clk_hub_div_if;
  logic clk_hub_5MHz;
  logic clk_hub_1MHz;
  logic clk_hub_100kHz;
  logic clk_hub_10kHz;
  logic clk_hub_1kHz;
  logic clk_hub_100Hz;
  logic clk_hub_10Hz;
  logic clk_hub_1Hz;
  modport master (
    output clk_hub_5MHz, clk_hub_1MHz, clk_hub_100kHz, clk_hub_10kHz,
           clk_hub_1kHz, clk_hub_100Hz, clk_hub_10Hz, clk_hub_1Hz
  );
  modport slave (
    input clk_hub_5MHz, clk_hub_1MHz, clk_hub_100kHz, clk_hub_10kHz,
          clk_hub_1kHz, clk_hub_100Hz, clk_hub_10Hz, clk_hub_1Hz
  );
endinterface

// File: rtl/clk_hub_div.sv
// clk_hub_div: eight independent 50%-duty divided clocks, each driven straight from a flop
module clk_hub_div #(
  parameter int CLK_IN_HZ = 50_000_000
) (
  input  logic         clk_hub_50MHz,
  input  logic         clk_hub_rst_n,
  clk_hub_div_if.master hub
);
  localparam int FREQ [8] = '{5_000_000, 1_000_000, 100_000, 10_000, 1_000, 100, 10, 1};
  logic [7:0] clk_o;
  genvar g;
  for (g = 0; g < 8; g++) begin : g_div
    localparam int HALF = CLK_IN_HZ / (2 * FREQ[g]);
    localparam int W = HALF > 1 ? $clog2(HALF) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    logic         out_q, tgl;
    // wrap the half-period counter and flag the toggle point
    always_comb begin
      tgl   = cnt_q == W'(HALF - 1);
      cnt_d = tgl ? '0 : cnt_q + 1'b1;
    end
    // counter and output flop; reset clears both without waiting for a clock
    always_ff @(posedge clk_hub_50MHz or negedge clk_hub_rst_n) begin
      if (!clk_hub_rst_n) begin
        cnt_q <= '0;
        out_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        out_q <= out_q ^ tgl;
      end
    end
    assign clk_o[g] = out_q;
  end
  assign hub.clk_hub_5MHz   = clk_o[0];
  assign hub.clk_hub_1MHz   = clk_o[1];
  assign hub.clk_hub_100kHz = clk_o[2];
  assign hub.clk_hub_10kHz  = clk_o[3];
  assign hub.clk_hub_1kHz   = clk_o[4];
  assign hub.clk_hub_100Hz  = clk_o[5];
  assign hub.clk_hub_10Hz   = clk_o[6];
  assign hub.clk_hub_1Hz    = clk_o[7];
endmodule

// File: tb/tb_clk_hub_div.sv
// tb_clk_hub_div: edge-count model of the clock hub checked every cycle, plus directed literal checks
module tb_clk_hub_div;
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  longint n = 0;
  int     tests = 0;
  int     fails = 0;
  logic [7:0] o;
  logic [7:0] prev;
  int     rise [8];
  localparam longint HALF [8] = '{5, 25, 250, 2_500, 25_000, 250_000, 2_500_000, 25_000_000};
  localparam int     RISE_1MS [8] = '{5000, 1000, 100, 10, 1, 0, 0, 0};
  clk_hub_div_if hub ();
  clk_hub_div #(.CLK_IN_HZ(50_000_000)) dut (
    .clk_hub_50MHz(clk),
    .clk_hub_rst_n(rst_n),
    .hub(hub.master)
  );
  assign o = {hub.clk_hub_1Hz, hub.clk_hub_10Hz, hub.clk_hub_100Hz, hub.clk_hub_1kHz,
              hub.clk_hub_10kHz, hub.clk_hub_100kHz, hub.clk_hub_1MHz, hub.clk_hub_5MHz};
  always #10 clk = ~clk;
  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // rising edges seen since the last reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else n <= n + 1;
  // output f is high exactly when an odd number of whole half periods have elapsed
  always @(negedge clk)
    for (int i = 0; i < 8; i++)
      check($sformatf("model out%0d n=%0d", i, n), longint'(o[i]),
            rst_n ? (n / HALF[i]) % 2 : 0);
  initial begin
    #95;
    check("reset all low", o, 0);
    #10 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("5M low edge4", o[0], 0);
    @(negedge clk);
    check("5M high edge5", o[0], 1);
    repeat (20) @(negedge clk);
    check("1M+5M high edge25", o[1:0], 2'b11);
    while ($time < 3333) #1;
    rst_n = 1'b0;
    #1 check("async reset low", o, 0);
    #48;
    check("reset held low", o, 0);
    rst_n = 1'b1;
    prev = '0;
    for (int i = 0; i < 8; i++) rise[i] = 0;
    for (int k = 1; k <= 50_000; k++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) if (o[i] && !prev[i]) rise[i]++;
      prev = o;
      if (k == 4)   check("restart 5M low edge4", o[0], 0);
      if (k == 5)   check("restart 5M high edge5", o[0], 1);
      if (k == 24)  check("restart 1M low edge24", o[1], 0);
      if (k == 25)  check("restart 1M+5M edge25", o[1:0], 2'b11);
      if (k == 249) check("100k low edge249", o[2], 0);
      if (k == 250) check("100k high edge250", o[2], 1);
      if (k == 2500) check("10k high edge2500", o[3], 1);
      if (k == 25_000) check("1k high edge25000", o[4], 1);
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("rises in 1ms out%0d", i), rise[i], RISE_1MS[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
